// File: rtl/mash_accumulator.sv
// mash_accumulator
// Three cascaded WIDTH-bit accumulators forming the front end of a MASH 1-1-1
// sigma-delta modulator.
// Stage 1 integrates the applied fractional word. Each later stage integrates
// the residue left in the stage before it. The registered carries c1..c3 feed
// the downstream noise-shaping differentiator.
//
// Ports
//   clk          single clock; all state changes on its rising edge
//   rst_n        asynchronous active-low reset
//   en           advance accumulators and dither LFSR this cycle
//   clear        synchronous clear of accumulators, carries and LFSR
//   frac_in      unsigned fractional word to capture
//   frac_load    capture strobe for frac_in (honoured regardless of en/clear)
//   dither_en    add a 1-LSB pseudo-random dither to the applied word
//   c1, c2, c3   registered carries of stages 1, 2 and 3
//   frac_active  word currently applied to stage 1
//   load_ack     one-cycle pulse after each capture
module mash_accumulator #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] frac_in,
  input  logic             frac_load,
  input  logic             dither_en,
  output logic             c1,
  output logic             c2,
  output logic             c3,
  output logic [WIDTH-1:0] frac_active,
  output logic             load_ack
);

  logic [WIDTH-1:0] acc1, acc2, acc3;
  logic [WIDTH-1:0] lfsr;
  logic             lfsr_fb;
  logic             dither_bit;
  logic [WIDTH-1:0] frac_eff;
  logic [WIDTH:0]   s1, s2, s3;

  // Fibonacci feedback. For WIDTH=16 these are taps 16,14,13,11, a
  // maximal-length polynomial.
  assign lfsr_fb = lfsr[WIDTH-1] ^ lfsr[WIDTH-3] ^ lfsr[WIDTH-4] ^ lfsr[WIDTH-6];

  // Dither is suppressed when the word is all ones. Adding 1 would wrap the
  // word to zero and collapse the average instead of nudging it up.
  assign dither_bit = dither_en & lfsr[0] & ~(&frac_active);
  assign frac_eff   = frac_active + {{(WIDTH-1){1'b0}}, dither_bit};

  // One combinational chain per cycle. Each stage sees the sum from the
  // stage before it, not the previous stage's registered value.
  assign s1 = {1'b0, acc1} + {1'b0, frac_eff};
  assign s2 = {1'b0, acc2} + {1'b0, s1[WIDTH-1:0]};
  assign s3 = {1'b0, acc3} + {1'b0, s2[WIDTH-1:0]};

  // Word capture is independent of clear and en.
  // When clear and frac_load arrive together, both take effect at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc1        <= '0;
      acc2        <= '0;
      acc3        <= '0;
      c1          <= 1'b0;
      c2          <= 1'b0;
      c3          <= 1'b0;
      lfsr        <= SEED;
      frac_active <= '0;
      load_ack    <= 1'b0;
    end else begin
      load_ack <= frac_load;
      if (frac_load) begin
        frac_active <= frac_in;
      end

      if (clear) begin
        acc1 <= '0;
        acc2 <= '0;
        acc3 <= '0;
        c1   <= 1'b0;
        c2   <= 1'b0;
        c3   <= 1'b0;
        lfsr <= SEED;
      end else if (en) begin
        acc1 <= s1[WIDTH-1:0];
        acc2 <= s2[WIDTH-1:0];
        acc3 <= s3[WIDTH-1:0];
        c1   <= s1[WIDTH];
        c2   <= s2[WIDTH];
        c3   <= s3[WIDTH];
        lfsr <= {lfsr[WIDTH-2:0], lfsr_fb};
      end else begin
        // Paused: the accumulators and LFSR hold.
        // The carries drop to zero, so the shaper sees no spurious pulses.
        c1 <= 1'b0;
        c2 <= 1'b0;
        c3 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mash_accumulator.sv
// tb_mash_accumulator
// Directed test bench for mash_accumulator (WIDTH=16).
// Expected carry patterns are worked out by hand from the accumulator
// recurrences:
//   word 0x8000 : c1,c2,c3 ones per 4 edges = 2,1,1
//   word 0x4000 : 8-edge cycle, (c1c2c3) = 000,001,010,101,000,011,010,100
//   word 0x2000 : first c1 on the 8th edge
module tb_mash_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clear = 1'b0;
  logic        frac_load = 1'b0;
  logic        dither_en = 1'b0;
  logic [15:0] frac_in = 16'h0000;
  logic        c1, c2, c3;
  logic [15:0] frac_active;
  logic        load_ack;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] pat4000 [8] = '{3'b000, 3'b001, 3'b010, 3'b101,
                              3'b000, 3'b011, 3'b010, 3'b100};

  mash_accumulator #(.WIDTH(16), .SEED(16'hACE1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .clear       (clear),
    .frac_in     (frac_in),
    .frac_load   (frac_load),
    .dither_en   (dither_en),
    .c1          (c1),
    .c2          (c2),
    .c3          (c3),
    .frac_active (frac_active),
    .load_ack    (load_ack)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  // Each call counts as one vector; any difference counts as a miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, clock them in, then settle just past the edge.
  task automatic applyStimulus(input logic e, input logic cl, input logic ld,
                               input logic [15:0] fi, input logic de);
    en        = e;
    clear     = cl;
    frac_load = ld;
    frac_in   = fi;
    dither_en = de;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n1, n2, n3;
    logic xseen;

    // Reset held low while inputs toggle: everything stays at zero.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, (i % 2) == 0, (i % 2) ? 16'hFFFF : 16'h0000, 1'b0);
      checkOutput("reset_carries", {29'd0, c1, c2, c3}, 32'd0);
      checkOutput("reset_frac_ack", {15'd0, load_ack, frac_active}, 32'd0);
    end
    rst_n = 1'b1;

    // Build some state, then reset asynchronously in the middle of a cycle.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h4000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h4000, 1'b0);
      checkOutput("prerun_pattern", {29'd0, c1, c2, c3}, {29'd0, pat4000[i]});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_carries", {29'd0, c1, c2, c3}, 32'd0);
    checkOutput("async_reset_frac", {16'd0, frac_active}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Word 0x8000 from a fresh reset.
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h8000, 1'b0);
    checkOutput("load8000_ack", {31'd0, load_ack}, 32'd1);
    checkOutput("load8000_frac", {16'd0, frac_active}, 32'h8000);
    checkOutput("load8000_carries", {29'd0, c1, c2, c3}, 32'd0);
    n1 = 0; n2 = 0; n3 = 0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h8000, 1'b0);
      if (i == 0) checkOutput("load8000_ack_drop", {31'd0, load_ack}, 32'd0);
      if (i < 4) checkOutput("c1_alternate", {31'd0, c1}, (i % 2));
      n1 += int'(c1); n2 += int'(c2); n3 += int'(c3);
    end
    checkOutput("c1_ones_8000", n1, 32);
    checkOutput("c2_ones_8000", n2, 16);
    checkOutput("c3_ones_8000", n3, 16);

    // Word 0x4000 with a clear on the load edge, and a 5-cycle pause mid-run.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h4000, 1'b0);
    checkOutput("load4000_ack", {31'd0, load_ack}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h4000, 1'b0);
      checkOutput("pattern4000_pre", {29'd0, c1, c2, c3}, {29'd0, pat4000[i]});
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h4000, 1'b0);
      checkOutput("pause_carries", {29'd0, c1, c2, c3}, 32'd0);
    end
    for (int i = 3; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h4000, 1'b0);
      checkOutput("pattern4000_resume", {29'd0, c1, c2, c3}, {29'd0, pat4000[i]});
    end
    n1 = 0; n2 = 0; n3 = 0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h4000, 1'b0);
      n1 += int'(c1); n2 += int'(c2); n3 += int'(c3);
    end
    checkOutput("c1_ones_4000", n1, 16);
    checkOutput("c2_ones_4000", n2, 24);
    checkOutput("c3_ones_4000", n3, 24);

    // Word 0x2000 with load and clear on the same edge, en low.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h2000, 1'b0);
    checkOutput("load2000_frac", {16'd0, frac_active}, 32'h2000);
    checkOutput("load2000_ack", {31'd0, load_ack}, 32'd1);
    checkOutput("load2000_carries", {29'd0, c1, c2, c3}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h2000, 1'b0);
      checkOutput("first_c1_2000", {31'd0, c1}, (i == 7) ? 32'd1 : 32'd0);
    end

    // frac_load held high recaptures every cycle.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
    checkOutput("hold_load_a", {15'd0, load_ack, frac_active}, {15'd0, 1'b1, 16'h1234});
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h5678, 1'b0);
    checkOutput("hold_load_b", {15'd0, load_ack, frac_active}, {15'd0, 1'b1, 16'h5678});
    applyStimulus(1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0);
    checkOutput("hold_load_end", {15'd0, load_ack, frac_active}, {15'd0, 1'b0, 16'h5678});

    // Zero word without dither: no carries at all.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);
    n1 = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      n1 += int'(c1) + int'(c2) + int'(c3);
    end
    checkOutput("zero_word_carries", n1, 0);

    // All-ones word with dither on: dither must not wrap the word.
    // The first edge produces no c1; every later edge produces one.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1);
    n1 = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b1);
      n1 += int'(c1);
    end
    checkOutput("ffff_dither_c1_ones", n1, 15);

    // Zero word with dither on, starting with acc1 at 0xFFF0.
    // The dither alone must eventually carry.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
    checkOutput("dither_load_carries", {29'd0, c1, c2, c3}, 32'd0);
    n1 = 0;
    xseen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      n1 += int'(c1);
      if ($isunknown({c1, c2, c3, load_ack, frac_active})) xseen = 1'b1;
    end
    checkOutput("dither_c1_seen", {31'd0, n1 > 0}, 32'd1);
    checkOutput("dither_no_x", {31'd0, xseen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
